// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared constants and types for the multicycle MIPS controller.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
// Contents: state encoding, opcode/funct constants, ALU control encodings, ALU op codes,
// and the DECODE dispatch helper. Optional macro: MIPS_BNE_EN (adds BNE to the dispatch).
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    // State that follows DECODE for a given opcode. Unsupported opcodes return to FETCH;
    // the controller uses that return value to flag illegal_op.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_RTYPE:     return S_EXECUTE;
            OP_BEQ:       return S_BRANCH;
`ifdef MIPS_BNE_EN
            OP_BNE:       return S_BRANCH;
`endif
            OP_ADDI:      return S_ADDIEX;
            OP_J:         return S_JUMP;
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Purpose: maps ALU op class + funct field to the 3-bit ALU control.
// Latency: combinational.
// Backpressure: none.
// Ports: alu_op (add/sub/funct-directed), funct (IR[5:0]) -> alu_control, funct_illegal
// (set only when alu_op selects funct decoding and funct is not a supported R-type).
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: Moore sequencing FSM for the multicycle MIPS datapath (mux selects, enables, ALU control).
// Latency: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles; +1 per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
// Backpressure: holds FETCH/MEMRD/MEMWR while mem_ready=0; no PC or register write while stalled.
// Ports: clk, rst (sync, active-high); opcode/funct from IR, zero from ALU, mem_ready from memory;
// datapath controls iord..reg_write, illegal_op pulse, debug state.
// Optional macro: MIPS_BNE_EN (opcode 000101 branches on zero=0; otherwise it is illegal).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               ir_write,
    output logic               mem_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t  state_q;
    alu_op_t alu_op;
    logic    funct_illegal;
    logic    pc_write;
    logic    branch;
    logic    ir_write_raw;
    logic    mem_write_raw;
    logic    reg_write_raw;
    logic    illegal_raw;
    logic    take_branch;
`ifdef MIPS_BNE_EN
    logic    is_bne_q;
`endif

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
`ifdef MIPS_BNE_EN
            is_bne_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH:   if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    state_q  <= decode_target(opcode);
`ifdef MIPS_BNE_EN
                    // Branch polarity is captured here so BRANCH does not depend on IR timing.
                    is_bne_q <= (opcode == OP_BNE);
`endif
                end
                S_MEMADR:  state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:   if (mem_ready) state_q <= S_FETCH;
                S_EXECUTE: state_q <= funct_illegal ? S_FETCH : S_ALUWB;
                S_ADDIEX:  state_q <= S_ADDIWB;
                default:   state_q <= S_FETCH;  // write-back states, BRANCH, JUMP, codes 12-15
            endcase
        end
    end

    always_comb begin
        iord          = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_OP_ADD;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                ir_write_raw = mem_ready;
                pc_write     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                illegal_raw = (decode_target(opcode) == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_op      = ALU_OP_FUNCT;
                illegal_raw = funct_illegal;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MIPS_BNE_EN
    assign take_branch = branch & (zero ^ is_bne_q);
`else
    assign take_branch = branch & zero;
`endif

    // rst masks every architectural write so nothing commits in a reset cycle.
    assign pc_en      = (pc_write | take_branch) & ~rst;
    assign ir_write   = ir_write_raw  & ~rst;
    assign mem_write  = mem_write_raw & ~rst;
    assign reg_write  = reg_write_raw & ~rst;
    assign illegal_op = illegal_raw   & ~rst;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: self-checking bench for multicycle_controller; per-instruction expected cycle sequences.
// Latency: n/a.
// Backpressure: mem_ready driven randomly or with fixed stall counts.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       iord, ir_write, mem_write, alu_src_a, pc_en, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail = 0;
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_fn = 6'd0;

    always #5 clk = ~clk;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .ir_write(ir_write), .mem_write(mem_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .state(state)
    );

    // {state, iord, ir_write, mem_write, alu_src_a, alu_src_b, alu_control, pc_src,
    //  pc_en, reg_dst, mem_to_reg, reg_write, illegal_op}
    logic [19:0] obs;
    assign obs = {state, iord, ir_write, mem_write, alu_src_a, alu_src_b, alu_control, pc_src,
                  pc_en, reg_dst, mem_to_reg, reg_write, illegal_op};

    typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_BNE, K_ADDI, K_J, K_ILL} kind_t;

    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] ev(input logic [3:0] st, input logic io, irw, mw, sa,
                                       input logic [1:0] sb, input logic [2:0] ctl,
                                       input logic [1:0] ps, input logic pe, rd, m2r, rw, il);
        return {st, io, irw, mw, sa, sb, ctl, ps, pe, rd, m2r, rw, il};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic kind_t classify(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
`ifdef MIPS_BNE_EN
            6'b000101: return K_BNE;
`endif
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    // {illegal, alu_control} for an R-type funct field
    function automatic logic [3:0] r_ctrl(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0_010;
            6'b100010: return 4'b0_110;
            6'b100100: return 4'b0_000;
            6'b100101: return 4'b0_001;
            6'b101010: return 4'b0_111;
            default:   return 4'b1_010;
        endcase
    endfunction

    // One cycle: drive inputs just after the falling edge, compare once they settle.
    task automatic cyc(input string tag, input logic r, input logic mr, input logic zr,
                       input logic [19:0] exp);
        @(negedge clk);
        rst = r; mem_ready = mr; zero = zr; opcode = cur_op; funct = cur_fn;
        #1;
        check_eq(tag, obs, exp);
    endtask

    task automatic fetch_decode(input int fs);
        kind_t k;
        k = classify(cur_op);
        for (int i = 0; i < fs; i++)
            cyc("fetch_stall", 0, 0, rb(), ev(0, 0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0,0,0,0));
        cyc("fetch", 0, 1, rb(), ev(0, 0,1,0,0, 2'b01, 3'b010, 2'b00, 1,0,0,0,0));
        cyc("decode", 0, rb(), rb(), ev(1, 0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0,0,0, k == K_ILL));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fs, input int ms);
        kind_t k;
        logic [3:0] rc;
        logic tk;
        cur_op = op; cur_fn = fn;
        k = classify(op);
        fetch_decode(fs);
        case (k)
            K_LW, K_SW: begin
                cyc("memadr", 0, rb(), rb(), ev(2, 0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0,0,0,0));
                if (k == K_LW) begin
                    for (int i = 0; i < ms; i++)
                        cyc("memrd_stall", 0, 0, rb(), ev(3, 1,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));
                    cyc("memrd", 0, 1, rb(), ev(3, 1,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));
                    cyc("memwb", 0, rb(), rb(), ev(4, 0,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,1,1,0));
                end else begin
                    for (int i = 0; i < ms; i++)
                        cyc("memwr_stall", 0, 0, rb(), ev(5, 1,0,1,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));
                    cyc("memwr", 0, 1, rb(), ev(5, 1,0,1,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));
                end
            end
            K_R: begin
                rc = r_ctrl(fn);
                cyc("execute", 0, rb(), rb(), ev(6, 0,0,0,1, 2'b00, rc[2:0], 2'b00, 0,0,0,0, rc[3]));
                if (!rc[3])
                    cyc("aluwb", 0, rb(), rb(), ev(7, 0,0,0,0, 2'b00, 3'b010, 2'b00, 0,1,0,1,0));
            end
            K_BEQ, K_BNE: begin
                tk = (k == K_BNE) ? !z : z;
                cyc("branch", 0, rb(), z, ev(8, 0,0,0,1, 2'b00, 3'b110, 2'b01, tk,0,0,0,0));
            end
            K_ADDI: begin
                cyc("addiex", 0, rb(), rb(), ev(9, 0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0,0,0,0));
                cyc("addiwb", 0, rb(), rb(), ev(10, 0,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,0,1,0));
            end
            K_J:  cyc("jump", 0, rb(), rb(), ev(11, 0,0,0,0, 2'b00, 3'b010, 2'b10, 1,0,0,0,0));
            default: ;  // illegal opcode: DECODE already returned to FETCH
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Reset: two edges with rst high, FETCH with every write masked.
        repeat (2) @(posedge clk);
        cyc("reset", 1, 1, 0, ev(0, 0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0,0,0,0));

        // Reset mid-LW while stalled in MEMRD, held two cycles.
        cur_op = 6'b100011; cur_fn = 6'd0;
        fetch_decode(0);
        cyc("lw_memadr", 0, 1, 0, ev(2, 0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0,0,0,0));
        cyc("lw_memrd_stall", 0, 0, 0, ev(3, 1,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));
        cyc("rst_in_memrd", 1, 1, 0, ev(3, 1,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));
        cyc("rst_to_fetch", 1, 1, 0, ev(0, 0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0,0,0,0));

        // Reset landing on MEMWB: register write must be suppressed.
        fetch_decode(0);
        cyc("lw_memadr2", 0, 1, 0, ev(2, 0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0,0,0,0));
        cyc("lw_memrd2", 0, 1, 0, ev(3, 1,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));
        cyc("rst_in_memwb", 1, 1, 0, ev(4, 0,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,1,0,0));

        // Reset during a stalled SW: mem_write must be suppressed.
        cur_op = 6'b101011;
        fetch_decode(0);
        cyc("sw_memadr", 0, 1, 0, ev(2, 0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0,0,0,0));
        cyc("rst_in_memwr", 1, 0, 0, ev(5, 1,0,0,0, 2'b00, 3'b010, 2'b00, 0,0,0,0,0));

        // Directed cases.
        run_instr(6'b100011, 6'd0, 0, 0, 0);        // LW, no wait states
        run_instr(6'b101011, 6'd0, 0, 0, 3);        // SW, three stall cycles in MEMWR
        run_instr(6'b000100, 6'd0, 1, 0, 0);        // BEQ taken
        run_instr(6'b000100, 6'd0, 0, 0, 0);        // BEQ not taken
        run_instr(6'b000000, 6'b101010, 0, 0, 0);   // SLT
        run_instr(6'b000000, 6'b111111, 0, 0, 0);   // unknown funct
        run_instr(6'b000101, 6'd0, 0, 0, 0);        // BNE / illegal depending on build
        run_instr(6'b000101, 6'd0, 1, 0, 0);
        run_instr(6'b001000, 6'd0, 0, 2, 0);        // ADDI after fetch stalls
        run_instr(6'b000010, 6'd0, 0, 0, 0);        // J
        run_instr(6'b111111, 6'd0, 0, 0, 0);        // unsupported opcode

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
            else fn = fns[$urandom_range(0, 4)];
            run_instr(op, fn, rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
